ov_pattern_src: RTL and testbench

Synthesizable OV7670-compatible pixel-stream transmitter. It generates `ov_pclk`, `ov_vs`, `ov_hs` and `cam_data` with the same framing, byte order and edge relationship as the sensor, so the camera capture path can be driven without a sensor attached. Uses:
- in-FPGA loopback and bring-up;
- deterministic finger-patch stimulus for the downsample/finger-detect logic.

---
 rtl/ov_pattern_src_if.sv | 11 +
 rtl/ov_pattern_src.sv | 191 +++++++++++++++++++
 tb/tb_ov_pattern_src.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov_pattern_src_if.sv
// Camera-side bus of the OV7670-style pattern source: pixel clock, sync strobes and data byte.
// The master drives the bus and the capture side samples it.
interface ov_pattern_src_if;
  logic       ov_pclk;
  logic       ov_vs;
  logic       ov_hs;
  logic [7:0] cam_data;

  modport master (output ov_pclk, ov_vs, ov_hs, cam_data);
  modport slave  (input  ov_pclk, ov_vs, ov_hs, cam_data);
endinterface

// File: rtl/ov_pattern_src.sv
// OV7670-compatible pixel-stream generator: VSYNC/HREF framing, YUV422 byte order (Y U Y V),
// and data that changes on the falling edge of pclk.
module ov_pattern_src #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic                mem_clk,
  input  logic                rst,
  input  logic                work_en,
  input  logic [1:0]          pattern_sel,
  input  logic [9:0]          patch_x0,
  input  logic [9:0]          patch_x1,
  input  logic [8:0]          patch_y0,
  input  logic [8:0]          patch_y1,
  ov_pattern_src_if.master    cam,
  output logic [15:0]         frame_cnt,
  output logic                busy
);
  localparam int         LINE_PCLK = 2 * H_ACTIVE + H_BLANK;
  localparam logic [11:0] PIX_LAST = 12'(LINE_PCLK - 1);
  localparam logic [11:0] BYTES    = 12'(2 * H_ACTIVE);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t      state_q, state_d;
  logic [11:0] pix_q, pix_d;
  logic [11:0] line_q, line_d;
  logic [11:0] line_last;
  logic        pclk_q, pclk_d;
  logic        vs_q, vs_d;
  logic        hs_q, hs_d;
  logic        busy_q, busy_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] frame_q, frame_d;
  logic [1:0]  sel_q, sel_d;
  logic [9:0]  x0_q, x0_d, x1_q, x1_d;
  logic [8:0]  y0_q, y0_d, y1_q, y1_d;
  logic        start_frame;
  logic        tick;

  logic [9:0]  x, xc;
  logic [8:0]  y;
  logic        in_x, in_xc, in_y, is_u;
  logic [7:0]  luma, chroma;

  // Every state update happens on the edge where pclk goes 1->0.
  assign tick = pclk_q;

  always_comb begin
    line_last = 12'(VS_LINES - 1);
    case (state_q)
      S_VBACK:  line_last = 12'(V_BACK - 1);
      S_ACTIVE: line_last = 12'(V_ACTIVE - 1);
      S_VFRONT: line_last = 12'(V_FRONT - 1);
      default:  line_last = 12'(VS_LINES - 1);
    endcase
  end

  always_comb begin
    pclk_d      = ~pclk_q;
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    frame_d     = frame_q;
    sel_d       = sel_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    start_frame = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: start_frame = work_en;
        default: begin
          if (pix_q == PIX_LAST) begin
            pix_d = '0;
            if (line_q == line_last) begin
              line_d = '0;
              case (state_q)
                S_VSYNC:  state_d = S_VBACK;
                S_VBACK:  state_d = S_ACTIVE;
                S_ACTIVE: state_d = S_VFRONT;
                default: begin
                  frame_d = frame_q + 16'd1;
                  if (work_en) start_frame = 1'b1;
                  else         state_d     = S_IDLE;
                end
              endcase
            end else begin
              line_d = line_q + 12'd1;
            end
          end else begin
            pix_d = pix_q + 12'd1;
          end
        end
      endcase
      // Frame configuration is frozen at VSYNC entry so a frame is never mixed.
      if (start_frame) begin
        state_d = S_VSYNC;
        pix_d   = '0;
        line_d  = '0;
        sel_d   = pattern_sel;
        x0_d    = patch_x0;
        x1_d    = patch_x1;
        y0_d    = patch_y0;
        y1_d    = patch_y1;
      end
    end
  end

  always_comb begin
    x      = pix_d[10:1];
    xc     = {pix_d[10:2], 1'b0};
    y      = line_d[8:0];
    is_u   = ~pix_d[1];
    in_x   = (x >= x0_q) && (x <= x1_q);
    in_xc  = (xc >= x0_q) && (xc <= x1_q);
    in_y   = (y >= y0_q) && (y <= y1_q);
    luma   = 8'h00;
    chroma = 8'h80;
    // Chroma of a pixel pair always comes from its even pixel.
    case (sel_q)
      2'd0: luma = {x[9:7], 5'b0};
      2'd1: begin
        luma   = x[9:2];
        chroma = is_u ? y[8:1] : 8'h80;
      end
      2'd2: begin
        luma = (in_x && in_y) ? 8'hC0 : 8'h10;
        if (in_xc && in_y) chroma = is_u ? 8'h70 : 8'hA0;
      end
      default: luma = frame_q[7:0];
    endcase

    vs_d   = vs_q;
    hs_d   = hs_q;
    busy_d = busy_q;
    data_d = data_q;
    if (tick) begin
      vs_d   = (state_d == S_VSYNC);
      busy_d = (state_d != S_IDLE);
      hs_d   = (state_d == S_ACTIVE) && (pix_d < BYTES);
      data_d = hs_d ? (pix_d[0] ? chroma : luma) : 8'h00;
    end
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      pclk_q  <= 1'b0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= 8'h00;
      frame_q <= 16'h0000;
      sel_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      pclk_q  <= pclk_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      sel_q   <= sel_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
    end
  end

  assign cam.ov_pclk  = pclk_q;
  assign cam.ov_vs    = vs_q;
  assign cam.ov_hs    = hs_q;
  assign cam.cam_data = data_q;
  assign frame_cnt    = frame_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_ov_pattern_src.sv
// Bench for ov_pattern_src with small framing parameters (20 ticks per line, 140 per frame).
// A byte-capture model samples on pclk rising, as the real capture path does.
module tb_ov_pattern_src;
  localparam int HA = 8, VA = 4, HB = 4, VSL = 1, VB = 1, VF = 1;

  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        work_en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [9:0]  patch_x0 = '0, patch_x1 = '0;
  logic [8:0]  patch_y0 = '0, patch_y1 = '0;
  logic [15:0] frame_cnt;
  logic        busy;

  ov_pattern_src_if cam();

  ov_pattern_src #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VS_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .mem_clk     (mem_clk),
    .rst         (rst),
    .work_en     (work_en),
    .pattern_sel (pattern_sel),
    .patch_x0    (patch_x0),
    .patch_x1    (patch_x1),
    .patch_y0    (patch_y0),
    .patch_y1    (patch_y1),
    .cam         (cam),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 mem_clk = ~mem_clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]   sel;
    logic [9:0]   x0, x1;
    logic [8:0]   y0, y1;
    int           row;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [8];

  // Capture model: byte grid of the most recent frame.
  logic [7:0] cap [VA][2*HA];
  int   cap_row = 0, cap_col = 0;
  logic prev_hs = 1'b0;

  always @(posedge cam.ov_pclk) begin
    #1;
    if (cam.ov_vs) begin
      cap_row = 0;
      cap_col = 0;
    end else if (cam.ov_hs) begin
      if (cap_row < VA && cap_col < 2*HA) cap[cap_row][cap_col] = cam.cam_data;
      cap_col++;
    end else if (prev_hs) begin
      cap_row++;
      cap_col = 0;
    end
    prev_hs = cam.ov_hs;
  end

  function automatic logic [127:0] cap_row_bits(input int r);
    logic [127:0] v = '0;
    for (int c = 0; c < 2*HA; c++) v[127-8*c -: 8] = cap[r][c];
    return v;
  endfunction

  function automatic logic [15:0] camera_read(input int r, input int p);
    return {cap[r][2*p], cap[r][2*p+1]};
  endfunction

  function automatic logic [127:0] flat_row(input logic [7:0] k);
    logic [127:0] v = '0;
    for (int c = 0; c < HA; c++) v[127-16*c -: 16] = {k, 8'h80};
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Returns just after the next tick edge (pclk 1->0).
  task automatic tick();
    do begin
      @(posedge mem_clk);
      #1;
    end while (cam.ov_pclk !== 1'b0);
  endtask

  task automatic run_frame(input vec_t v);
    pattern_sel = v.sel;
    patch_x0 = v.x0; patch_x1 = v.x1;
    patch_y0 = v.y0; patch_y1 = v.y1;
    work_en = 1'b1;
    tick();
    work_en = 1'b0;
    repeat (150) tick();
  endtask

  task automatic pulse_reset();
    @(negedge mem_clk) rst = 1'b1;
    @(negedge mem_clk) rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int tog, any_act, vs_rise, hs_rise, vs_ticks, hs_ticks, pulses, run, maxrun;
    int busy_ticks, busy_fall, vs_rises, busy_low, y_bad;
    logic last_pclk, prev_busy, prev_vs, hs_seen;
    logic [15:0] f0;

    vecs[0] = '{2'd1, 10'd0, 10'd0, 9'd0, 9'd0, 2, 128'h00010080000100800101018001010180};
    vecs[1] = '{2'd1, 10'd0, 10'd0, 9'd0, 9'd0, 0, 128'h00000080000000800100018001000180};
    vecs[2] = '{2'd1, 10'd0, 10'd0, 9'd0, 9'd0, 3, 128'h00010080000100800101018001010180};
    vecs[3] = '{2'd0, 10'd0, 10'd0, 9'd0, 9'd0, 1, 128'h00800080008000800080008000800080};
    vecs[4] = '{2'd2, 10'd2, 10'd3, 9'd1, 9'd1, 1, 128'h10801080C070C0A01080108010801080};
    vecs[5] = '{2'd2, 10'd2, 10'd3, 9'd1, 9'd1, 0, 128'h10801080108010801080108010801080};
    vecs[6] = '{2'd2, 10'd5, 10'd2, 9'd0, 9'd3, 1, 128'h10801080108010801080108010801080};
    vecs[7] = '{2'd2, 10'd3, 10'd4, 9'd0, 9'd3, 2, 128'h108010801080C080C07010A010801080};

    // Reset and idle behaviour
    repeat (3) @(posedge mem_clk);
    #1;
    check("rst_pclk", cam.ov_pclk, 0);
    check("rst_outputs", {cam.ov_vs, cam.ov_hs, busy, cam.cam_data, frame_cnt}, 0);
    @(negedge mem_clk) rst = 1'b0;
    tog = 0; any_act = 0;
    last_pclk = cam.ov_pclk;
    repeat (100) begin
      @(posedge mem_clk);
      #1;
      if (cam.ov_pclk !== last_pclk) tog++;
      last_pclk = cam.ov_pclk;
      if (cam.ov_vs || cam.ov_hs || busy || cam.cam_data != 8'h00) any_act++;
    end
    check("idle_pclk_toggles", tog, 100);
    check("idle_quiet", any_act, 0);
    check("idle_frame_cnt", frame_cnt, 0);

    // Single ramp frame: framing timing
    pattern_sel = 2'd1;
    work_en = 1'b1;
    vs_rise = -1; hs_rise = -1; vs_ticks = 0; hs_ticks = 0; pulses = 0;
    run = 0; maxrun = 0; busy_ticks = 0; busy_fall = -1; prev_busy = 1'b0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (t == 0) work_en = 1'b0;
      if (cam.ov_vs) begin
        vs_ticks++;
        if (vs_rise < 0) vs_rise = t;
      end
      if (cam.ov_hs) begin
        hs_ticks++;
        run++;
        if (run == 1) pulses++;
        if (run > maxrun) maxrun = run;
        if (hs_rise < 0) hs_rise = t;
      end else begin
        run = 0;
      end
      if (busy) busy_ticks++;
      if (!busy && prev_busy && busy_fall < 0) busy_fall = t;
      prev_busy = busy;
    end
    check("vs_rise_same_tick", vs_rise, 0);
    check("vs_width", vs_ticks, 20);
    check("href_delay", hs_rise - vs_rise, 40);
    check("href_pulses", pulses, 4);
    check("href_width", maxrun, 16);
    check("href_total", hs_ticks, 64);
    check("busy_ticks", busy_ticks, 140);
    check("busy_fall", busy_fall - vs_rise, 140);
    check("frame_cnt_1", frame_cnt, 1);
    check("ramp_row2", cap_row_bits(2), 128'h00010080000100800101018001010180);

    // Table of pattern rows
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i]);
      check($sformatf("vec%0d_sel%0d_row%0d", i, vecs[i].sel, vecs[i].row),
            cap_row_bits(vecs[i].row), vecs[i].exp);
    end

    // Patch via 16-bit capture words
    run_frame(vecs[4]);
    check("cam_word_r1p2", camera_read(1, 2), 16'hC070);
    check("cam_word_r1p3", camera_read(1, 3), 16'hC0A0);
    check("cam_word_r1p0", camera_read(1, 0), 16'h1080);
    y_bad = 0;
    for (int r = 0; r < VA; r++)
      for (int p = 0; p < HA; p++)
        if (!(r == 1 && (p == 2 || p == 3)) && cap[r][2*p] != 8'h10) y_bad++;
    check("patch_outside_y", y_bad, 0);

    // work_en dropped during active row 2
    f0 = frame_cnt;
    pattern_sel = 2'd1;
    work_en = 1'b1;
    busy_ticks = 0; vs_rises = 0; prev_vs = 1'b0;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (t == 85) begin
        check("drop_in_active", cam.ov_hs, 1);
        work_en = 1'b0;
      end
      if (busy) busy_ticks++;
      if (cam.ov_vs && !prev_vs) vs_rises++;
      prev_vs = cam.ov_vs;
    end
    check("drop_busy_ticks", busy_ticks, 140);
    check("drop_vs_rises", vs_rises, 1);
    check("drop_frame_cnt", frame_cnt, f0 + 16'd1);
    check("drop_idle_busy", busy, 0);

    // Asynchronous reset during ACTIVE
    pattern_sel = 2'd2;
    patch_x0 = 10'd0; patch_x1 = 10'd7; patch_y0 = 9'd0; patch_y1 = 9'd3;
    work_en = 1'b1;
    hs_seen = 1'b0;
    for (int t = 0; t < 100 && !hs_seen; t++) begin
      tick();
      if (t >= 45 && cam.ov_hs) hs_seen = 1'b1;
    end
    check("rst_pre_hs_seen", hs_seen, 1);
    @(posedge mem_clk);
    #1;
    check("rst_pre_state", {cam.ov_pclk, cam.ov_hs}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async_pclk", cam.ov_pclk, 0);
    check("async_hs_data", {cam.ov_hs, cam.cam_data}, 0);
    check("async_vs_busy_cnt", {cam.ov_vs, busy, frame_cnt}, 0);
    @(negedge mem_clk) rst = 1'b0;
    busy_ticks = 0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (cam.ov_vs) work_en = 1'b0;
      if (busy) busy_ticks++;
      if (frame_cnt == 16'd1 && !busy) break;
    end
    check("post_rst_frame_cnt", frame_cnt, 1);
    check("post_rst_busy_ticks", busy_ticks, 140);
    check("post_rst_row1", cap_row_bits(1), 128'hC070C0A0C070C0A0C070C0A0C070C0A0);

    // Back-to-back flat frames, mid-frame pattern change
    pulse_reset();
    pattern_sel = 2'd3;
    work_en = 1'b1;
    busy_low = 0; vs_rises = 0; prev_vs = 1'b0;
    for (int t = 0; t < 580; t++) begin
      tick();
      if (t == 330) pattern_sel = 2'd1;
      if (t == 425) work_en = 1'b0;
      if (t < 560 && !busy) busy_low++;
      if (cam.ov_vs && !prev_vs) vs_rises++;
      prev_vs = cam.ov_vs;
      for (int k = 0; k < 3; k++) begin
        if (t == 140*k + 130) begin
          check($sformatf("flat_f%0d_row0", k), cap_row_bits(0), flat_row(8'(k)));
          check($sformatf("flat_f%0d_row3", k), cap_row_bits(3), flat_row(8'(k)));
        end
      end
      if (t == 550) check("next_vsync_ramp_row2", cap_row_bits(2), 128'h00010080000100800101018001010180);
    end
    check("b2b_busy_low", busy_low, 0);
    check("b2b_vs_rises", vs_rises, 4);
    check("b2b_frame_cnt", frame_cnt, 4);
    check("b2b_final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
